// File: rtl/tl_fc_dllp_rx.sv
// Receive-side flow-control DLLP parser for VC0: CRC check, FC init sequencing
// and conversion of the partner's modular credit limits into credit increments.
module tl_fc_dllp_rx #(
    parameter int HDR_WIDTH  = 8,
    parameter int DATA_WIDTH = 12,
    parameter int CHECK_CRC  = 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    dllp_valid_i,
    input  logic [47:0]                             dllp_i,
    input  logic                                    link_down_i,
    // Packed MSB-first as {ph, pd, nph, npd, cplh, cpld}
    output logic [3*(HDR_WIDTH+DATA_WIDTH)-1:0]     fc_update_o,
    output logic                                    fc_valid_o,
    output logic                                    fc_init_done_o,
    output logic                                    fi1_o,
    output logic                                    crc_err_o,
    output logic [7:0]                              crc_err_cnt_o
);
    localparam int CW = HDR_WIDTH + DATA_WIDTH;

    typedef enum logic [1:0] {FC_INIT1, FC_INIT2, FC_ACTIVE} fc_state_t;

    fc_state_t              r_state, w_state_next;
    logic [HDR_WIDTH-1:0]   r_lim_h [3];
    logic [HDR_WIDTH-1:0]   w_lim_h_next [3];
    logic [DATA_WIDTH-1:0]  r_lim_d [3];
    logic [DATA_WIDTH-1:0]  w_lim_d_next [3];
    logic [2:0]             r_inf_h, w_inf_h_next;
    logic [2:0]             r_inf_d, w_inf_d_next;
    logic [2:0]             r_rcv, w_rcv_next;
    logic                   r_fc_valid, w_fc_valid_next;
    logic [3*CW-1:0]        r_fc_update, w_upd_flat;
    logic                   r_crc_err, w_crc_err_next;
    logic [7:0]             r_crc_cnt, w_crc_cnt_next;

    logic [HDR_WIDTH-1:0]   w_upd_h [3];
    logic [DATA_WIDTH-1:0]  w_upd_d [3];
    logic [HDR_WIDTH-1:0]   w_hdr, w_dh;
    logic [DATA_WIDTH-1:0]  w_data, w_dd;
    logic [1:0]             w_type;
    logic                   w_is_init1, w_is_init2, w_is_upd, w_dec_ok, w_crc_ok, w_do_upd;
    logic [15:0]            w_crc;

    // Serial CRC-16 (poly 100Bh, seed FFFFh), each byte fed LSB first; the
    // complemented remainder is bit-reversed per byte to match bytes 4-5.
    function automatic logic [15:0] f_dllp_crc(input logic [31:0] data);
        logic [15:0] c;
        logic [15:0] r;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 8; j++) begin
                fb = c[15] ^ data[24 - 8*i + j];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h100B : 16'h0000);
            end
        end
        c = ~c;
        for (int k = 0; k < 8; k++) begin
            r[8 + k] = c[15 - k];
            r[k]     = c[7 - k];
        end
        return r;
    endfunction

    assign w_crc      = f_dllp_crc(dllp_i[47:16]);
    assign w_crc_ok   = (CHECK_CRC == 0) || (w_crc == dllp_i[15:0]);
    assign w_type     = dllp_i[45:44];
    assign w_is_init1 = (dllp_i[47:46] == 2'b01);
    assign w_is_init2 = (dllp_i[47:46] == 2'b11);
    assign w_is_upd   = (dllp_i[47:46] == 2'b10);
    assign w_dec_ok   = (dllp_i[43:40] == 4'b0000) && (w_type != 2'b11);
    assign w_hdr      = dllp_i[37:30];
    assign w_data     = dllp_i[27:16];

    always_comb begin
        w_state_next    = r_state;
        w_lim_h_next    = r_lim_h;
        w_lim_d_next    = r_lim_d;
        w_inf_h_next    = r_inf_h;
        w_inf_d_next    = r_inf_d;
        w_rcv_next      = r_rcv;
        w_fc_valid_next = 1'b0;
        w_crc_err_next  = 1'b0;
        w_crc_cnt_next  = r_crc_cnt;
        w_upd_h         = '{default: '0};
        w_upd_d         = '{default: '0};
        w_do_upd        = 1'b0;
        w_dh            = '0;
        w_dd            = '0;
        if (link_down_i) begin
            w_state_next = FC_INIT1;
            w_lim_h_next = '{default: '0};
            w_lim_d_next = '{default: '0};
            w_inf_h_next = '0;
            w_inf_d_next = '0;
            w_rcv_next   = '0;
        end else if (dllp_valid_i && !w_crc_ok) begin
            w_crc_err_next = 1'b1;
            if (r_crc_cnt != 8'hFF)
                w_crc_cnt_next = r_crc_cnt + 8'd1;
        end else if (dllp_valid_i && w_dec_ok) begin
            case (r_state)
                FC_INIT1: begin
                    if (w_is_init1 && !r_rcv[w_type]) begin
                        w_rcv_next[w_type]   = 1'b1;
                        w_lim_h_next[w_type] = w_hdr;
                        w_lim_d_next[w_type] = w_data;
                        w_inf_h_next[w_type] = (w_hdr == '0);
                        w_inf_d_next[w_type] = (w_data == '0);
                        // A zero advertisement means infinite credit
                        w_upd_h[w_type]      = (w_hdr == '0) ? '1 : w_hdr;
                        w_upd_d[w_type]      = (w_data == '0) ? '1 : w_data;
                        w_fc_valid_next      = 1'b1;
                        if (&w_rcv_next)
                            w_state_next = FC_INIT2;
                    end
                end
                FC_INIT2: begin
                    if (w_is_init2 || w_is_upd)
                        w_state_next = FC_ACTIVE;
                    w_do_upd = w_is_upd;
                end
                FC_ACTIVE: w_do_upd = w_is_upd;
                default:   w_state_next = FC_INIT1;
            endcase
            if (w_do_upd) begin
                w_dh = r_inf_h[w_type] ? '0 : (w_hdr - r_lim_h[w_type]);
                w_dd = r_inf_d[w_type] ? '0 : (w_data - r_lim_d[w_type]);
                if (!r_inf_h[w_type])
                    w_lim_h_next[w_type] = w_hdr;
                if (!r_inf_d[w_type])
                    w_lim_d_next[w_type] = w_data;
                w_upd_h[w_type] = w_dh;
                w_upd_d[w_type] = w_dd;
                w_fc_valid_next = (|w_dh) || (|w_dd);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_pack
            assign w_upd_flat[(3-gi)*CW-1 -: CW] = {w_upd_h[gi], w_upd_d[gi]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= FC_INIT1;
            r_lim_h     <= '{default: '0};
            r_lim_d     <= '{default: '0};
            r_inf_h     <= '0;
            r_inf_d     <= '0;
            r_rcv       <= '0;
            r_fc_valid  <= 1'b0;
            r_fc_update <= '0;
            r_crc_err   <= 1'b0;
            r_crc_cnt   <= '0;
        end else begin
            r_state     <= w_state_next;
            r_lim_h     <= w_lim_h_next;
            r_lim_d     <= w_lim_d_next;
            r_inf_h     <= w_inf_h_next;
            r_inf_d     <= w_inf_d_next;
            r_rcv       <= w_rcv_next;
            r_fc_valid  <= w_fc_valid_next;
            r_fc_update <= w_upd_flat;
            r_crc_err   <= w_crc_err_next;
            r_crc_cnt   <= w_crc_cnt_next;
        end
    end

    assign fc_update_o    = r_fc_update;
    assign fc_valid_o     = r_fc_valid;
    assign fc_init_done_o = (r_state == FC_ACTIVE);
    assign fi1_o          = &r_rcv;
    assign crc_err_o      = r_crc_err;
    assign crc_err_cnt_o  = r_crc_cnt;
endmodule

// File: tb/tb_tl_fc_dllp_rx.sv
// Bench for tl_fc_dllp_rx: directed and random DLLPs against a behavioural
// model of the FC init/update rules kept with plain integer arithmetic.
module tb_tl_fc_dllp_rx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dllp_valid_i = 1'b0;
    logic [47:0] dllp_i = '0;
    logic        link_down_i = 1'b0;
    logic [59:0] fc_update_o;
    logic        fc_valid_o;
    logic        fc_init_done_o;
    logic        fi1_o;
    logic        crc_err_o;
    logic [7:0]  crc_err_cnt_o;

    tl_fc_dllp_rx #(.HDR_WIDTH(8), .DATA_WIDTH(12), .CHECK_CRC(1)) dut (
        .clk            (clk),
        .rst            (rst),
        .dllp_valid_i   (dllp_valid_i),
        .dllp_i         (dllp_i),
        .link_down_i    (link_down_i),
        .fc_update_o    (fc_update_o),
        .fc_valid_o     (fc_valid_o),
        .fc_init_done_o (fc_init_done_o),
        .fi1_o          (fi1_o),
        .crc_err_o      (crc_err_o),
        .crc_err_cnt_o  (crc_err_cnt_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: 0 = InitFC1 phase, 1 = InitFC2 phase, 2 = active
    int m_state;
    int m_lim_h [3];
    int m_lim_d [3];
    bit m_inf_h [3];
    bit m_inf_d [3];
    bit m_rcv   [3];
    int m_cnt;
    int e_h [3];
    int e_d [3];
    bit e_valid;
    bit e_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [15:0] ref_crc(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0]  by [4];
        int          crc;
        int          bitv;
        logic [15:0] rem;
        logic [7:0]  o4, o5;
        by[0] = b0; by[1] = b1; by[2] = b2; by[3] = b3;
        crc = 'hFFFF;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 8; j++) begin
                bitv = int'(by[i][j]) ^ ((crc >> 15) & 1);
                crc  = ((crc << 1) & 'hFFFF) ^ (bitv != 0 ? 'h100B : 0);
            end
        end
        rem = 16'(crc ^ 'hFFFF);
        for (int k = 0; k < 8; k++) begin
            o4[k] = rem[15 - k];
            o5[k] = rem[7 - k];
        end
        return {o4, o5};
    endfunction

    function automatic logic [47:0] mk(input logic [7:0] b0, input int h, input int d);
        logic [7:0]  hh;
        logic [11:0] dd;
        logic [7:0]  b1, b2, b3;
        hh = 8'(h);
        dd = 12'(d);
        b1 = {2'($urandom_range(0, 3)), hh[7:2]};
        b2 = {hh[1:0], 2'($urandom_range(0, 3)), dd[11:8]};
        b3 = dd[7:0];
        return {b0, b1, b2, b3, ref_crc(b0, b1, b2, b3)};
    endfunction

    task automatic m_clear_fc();
        m_state = 0;
        for (int i = 0; i < 3; i++) begin
            m_lim_h[i] = 0; m_lim_d[i] = 0;
            m_inf_h[i] = 0; m_inf_d[i] = 0; m_rcv[i] = 0;
        end
    endtask

    task automatic m_update(input int idx, input int h, input int d);
        int dh, dd;
        dh = m_inf_h[idx] ? 0 : (h - m_lim_h[idx] + 256) % 256;
        dd = m_inf_d[idx] ? 0 : (d - m_lim_d[idx] + 4096) % 4096;
        if (!m_inf_h[idx]) m_lim_h[idx] = h;
        if (!m_inf_d[idx]) m_lim_d[idx] = d;
        e_h[idx] = dh;
        e_d[idx] = dd;
        e_valid  = (dh != 0) || (dd != 0);
    endtask

    task automatic model(input logic [7:0] b0, input int h, input int d, input bit bad, input bit ld);
        int kind, idx;
        e_valid = 0; e_err = 0;
        for (int i = 0; i < 3; i++) begin e_h[i] = 0; e_d[i] = 0; end
        kind = 0; idx = 0;
        if (b0 inside {8'h40, 8'h50, 8'h60}) begin kind = 1; idx = (int'(b0) - 'h40) / 16; end
        if (b0 inside {8'hC0, 8'hD0, 8'hE0}) begin kind = 2; idx = (int'(b0) - 'hC0) / 16; end
        if (b0 inside {8'h80, 8'h90, 8'hA0}) begin kind = 3; idx = (int'(b0) - 'h80) / 16; end
        if (ld) begin
            m_clear_fc();
        end else if (bad) begin
            e_err = 1;
            if (m_cnt < 255) m_cnt++;
        end else if (m_state == 0) begin
            if (kind == 1 && !m_rcv[idx]) begin
                m_rcv[idx]   = 1;
                m_lim_h[idx] = h;
                m_lim_d[idx] = d;
                m_inf_h[idx] = (h == 0);
                m_inf_d[idx] = (d == 0);
                e_h[idx]     = (h == 0) ? 255 : h;
                e_d[idx]     = (d == 0) ? 4095 : d;
                e_valid      = 1;
                if (m_rcv[0] && m_rcv[1] && m_rcv[2]) m_state = 1;
            end
        end else if (m_state == 1) begin
            if (kind == 2 || kind == 3) m_state = 2;
            if (kind == 3) m_update(idx, h, d);
        end else begin
            if (kind == 3) m_update(idx, h, d);
        end
    endtask

    function automatic logic [59:0] exp_flat();
        return {e_h[0][7:0], e_d[0][11:0], e_h[1][7:0], e_d[1][11:0], e_h[2][7:0], e_d[2][11:0]};
    endfunction

    task automatic send(input logic [7:0] b0, input int h, input int d, input bit bad,
                        input bit ld, input string tag);
        logic [47:0] w;
        w = mk(b0, h, d);
        if (bad) w[0] = ~w[0];
        @(negedge clk);
        dllp_valid_i = 1'b1;
        dllp_i       = w;
        link_down_i  = ld;
        model(b0, h, d, bad, ld);
        @(posedge clk);
        #1;
        dllp_valid_i = 1'b0;
        link_down_i  = 1'b0;
        $display("[TB] %s b0=%02h h=%02h d=%03h bad=%0d ld=%0d -> valid=%0d upd=%015h err=%0d cnt=%0d fi1=%0d done=%0d",
                 tag, b0, h, d, bad, ld, fc_valid_o, fc_update_o, crc_err_o, crc_err_cnt_o,
                 fi1_o, fc_init_done_o);
        chk({tag, " valid"}, fc_valid_o, e_valid);
        chk({tag, " update"}, fc_update_o, exp_flat());
        chk({tag, " crc_err"}, crc_err_o, e_err);
        chk({tag, " crc_cnt"}, crc_err_cnt_o, m_cnt);
        chk({tag, " fi1"}, fi1_o, (m_state != 0));
        chk({tag, " done"}, fc_init_done_o, (m_state == 2));
    endtask

    logic [7:0] tbl [13] = '{8'h40, 8'h50, 8'h60, 8'hC0, 8'hD0, 8'hE0,
                             8'h80, 8'h90, 8'hA0, 8'h81, 8'h00, 8'h70, 8'h82};

    initial begin
        m_clear_fc();
        m_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset valid", fc_valid_o, 1'b0);
        chk("reset update", fc_update_o, 60'h0);
        chk("reset done", fc_init_done_o, 1'b0);
        chk("reset fi1", fi1_o, 1'b0);
        chk("reset crc_err", crc_err_o, 1'b0);
        chk("reset cnt", crc_err_cnt_o, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        send(8'h40, 'h20, 'h100, 0, 0, "init1_p");
        chk("init1_p plan", fc_update_o, {8'h20, 12'h100, 40'h0});
        send(8'h50, 'h10, 'h000, 0, 0, "init1_np");
        chk("init1_np plan", fc_update_o, {20'h0, 8'h10, 12'hFFF, 20'h0});
        send(8'h40, 'h33, 'h033, 0, 0, "init1_p_repeat");
        send(8'h60, 'h00, 'h000, 0, 0, "init1_cpl");
        chk("init1_cpl plan", fc_update_o, {40'h0, 8'hFF, 12'hFFF});
        chk("fi1 after third", fi1_o, 1'b1);

        send(8'hC0, 'h55, 'h555, 0, 0, "init2_p");
        chk("init2 done", fc_init_done_o, 1'b1);
        send(8'h80, 'h28, 'h140, 0, 0, "upd_p");
        chk("upd_p plan", fc_update_o, {8'h08, 12'h040, 40'h0});
        send(8'h80, 'h28, 'h140, 0, 0, "upd_p_resend");
        chk("resend no pulse", fc_valid_o, 1'b0);

        send(8'h80, 'hFE, 'hFF0, 0, 0, "upd_p_pre_wrap");
        send(8'h80, 'h03, 'h010, 0, 0, "upd_p_wrap");
        chk("wrap plan", fc_update_o, {8'h05, 12'h020, 40'h0});

        send(8'h80, 'h07, 'h030, 1, 0, "bad_crc");
        chk("bad crc cnt", crc_err_cnt_o, 8'h01);
        for (int i = 0; i < 300; i++) send(8'h80, i % 256, i, 1, 0, "bad_crc_burst");
        chk("crc cnt saturated", crc_err_cnt_o, 8'hFF);
        send(8'h80, 'h07, 'h030, 0, 0, "good_after_bad");
        chk("good_after_bad plan", fc_update_o, {8'h04, 12'h020, 40'h0});

        send(8'h90, 'h18, $urandom_range(0, 4095), 0, 0, "upd_np_inf");
        chk("upd_np_inf plan", fc_update_o, {20'h0, 8'h08, 12'h000, 20'h0});
        send(8'h81, 'h40, 'h400, 0, 0, "vc1_ignored");
        chk("vc1 no pulse", fc_valid_o, 1'b0);

        send(8'h80, 'h30, 'h150, 0, 1, "link_down");
        chk("link_down no pulse", fc_valid_o, 1'b0);
        chk("link_down done", fc_init_done_o, 1'b0);
        chk("link_down cnt kept", crc_err_cnt_o, 8'hFF);
        send(8'h40, 'h04, 'h020, 0, 0, "reinit_p");
        chk("reinit_p plan", fc_update_o, {8'h04, 12'h020, 40'h0});

        for (int i = 0; i < 80; i++) begin
            logic [7:0] b0;
            int         h;
            b0 = tbl[$urandom_range(0, 12)];
            h  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(0, 255);
            send(b0, h, $urandom_range(0, 4095), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 19) == 0), "random");
        end

        @(negedge clk);
        dllp_valid_i = 1'b1;
        dllp_i       = mk(8'h80, 'h11, 'h111);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst valid", fc_valid_o, 1'b0);
        chk("async rst update", fc_update_o, 60'h0);
        chk("async rst done", fc_init_done_o, 1'b0);
        chk("async rst fi1", fi1_o, 1'b0);
        chk("async rst crc_err", crc_err_o, 1'b0);
        chk("async rst cnt", crc_err_cnt_o, 8'h00);
        @(negedge clk);
        dllp_valid_i = 1'b0;
        rst = 1'b0;
        m_clear_fc();
        m_cnt = 0;
        send(8'h60, 'h09, 'h090, 0, 0, "post_rst_cpl");
        chk("post_rst_cpl plan", fc_update_o, {40'h0, 8'h09, 12'h090});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
